// File: rtl/serpent_xts_sector_ctrl_if.sv
// ============================================================================
// Module   : serpent_xts_sector_ctrl_if
// Brief    : Command, stream and core-side bundle of the XTS sector sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface serpent_xts_sector_ctrl_if #(
    parameter int NBLK_W = 6
);
    logic              start;
    logic [255:0]      key1;
    logic [255:0]      key2;
    logic [127:0]      tweak;
    logic [NBLK_W-1:0] nblk;

    logic              in_valid;
    logic [127:0]      in_data;
    logic              in_ready;

    logic              out_valid;
    logic [127:0]      out_data;
    logic              out_ready;

    logic              busy;
    logic              done;
    logic              error;

    logic [255:0]      core_key;
    logic              core_key_valid;
    logic              core_enable;
    logic [127:0]      core_data;
    logic [127:0]      core_rdata;
    logic              core_valid;

    // Sequencer side
    modport slave (
        input  start, key1, key2, tweak, nblk,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready,
        output busy, done, error,
        output core_key, core_key_valid, core_enable, core_data,
        input  core_rdata, core_valid
    );

    // Environment side: host, DMA streams and encrypt core
    modport master (
        output start, key1, key2, tweak, nblk,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready,
        input  busy, done, error,
        input  core_key, core_key_valid, core_enable, core_data,
        output core_rdata, core_valid
    );
endinterface

`default_nettype wire

// File: rtl/serpent_xts_sector_ctrl.sv
// ============================================================================
// Module   : serpent_xts_sector_ctrl
// Brief    : XTS sector sequencer around a single-shot Serpent encrypt core.
//            Optional core watchdog: SERPENT_XTS_CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serpent_xts_sector_ctrl #(
    parameter int NBLK_W      = 6
`ifdef SERPENT_XTS_CTRL_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 1023
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serpent_xts_sector_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TWK_RUN = 3'd1,
        S_GAP     = 3'd2,
        S_BLK_IN  = 3'd3,
        S_BLK_RUN = 3'd4,
        S_BLK_OUT = 3'd5
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [255:0]      key1_q;
    logic [255:0]      key2_q;
    logic [127:0]      t_q;
    logic [127:0]      x_q;
    logic [127:0]      c_q;
    logic [NBLK_W-1:0] nblk_q;
    logic [NBLK_W-1:0] cnt_q;
    logic              done_q;

    logic [127:0]      t_alpha;
    logic              last_blk;
    logic              tmo_hit;

    // Multiply by alpha in GF(2^128), x^128 + x^7 + x^2 + x + 1
    assign t_alpha  = {t_q[126:0], 1'b0} ^ (t_q[127] ? 128'h87 : 128'h0);
    assign last_blk = (cnt_q == (nblk_q - NBLK_W'(1)));

`ifdef SERPENT_XTS_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             error_q;
    logic             core_run;

    assign core_run = (state_q == S_TWK_RUN) || (state_q == S_BLK_RUN);
    assign tmo_hit  = core_run && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q   <= '0;
            error_q <= 1'b0;
        end else begin
            // Restart the watchdog whenever a core op is entered
            if (state_d != state_q) begin
                tmo_q <= '0;
            end else if (core_run) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if ((state_q == S_IDLE) && bus.start) begin
                error_q <= 1'b0;
            end else if (tmo_hit && !bus.core_valid) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus.error = error_q;
`else
    assign tmo_hit   = 1'b0;
    assign bus.error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        bus.in_ready       = 1'b0;
        bus.out_valid      = 1'b0;
        bus.out_data       = '0;
        bus.core_key       = '0;
        bus.core_key_valid = 1'b0;
        bus.core_enable    = 1'b0;
        bus.core_data      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.nblk != '0)) begin
                    state_d = S_TWK_RUN;
                end
            end
            S_TWK_RUN: begin
                bus.core_key       = key2_q;
                bus.core_data      = t_q;
                bus.core_key_valid = 1'b1;
                bus.core_enable    = 1'b1;
                if (bus.core_valid) begin
                    state_d = S_GAP;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                state_d = S_BLK_IN;
            end
            S_BLK_IN: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = S_BLK_RUN;
                end
            end
            S_BLK_RUN: begin
                bus.core_key       = key1_q;
                bus.core_data      = x_q;
                bus.core_key_valid = 1'b1;
                bus.core_enable    = 1'b1;
                if (bus.core_valid) begin
                    state_d = S_BLK_OUT;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_BLK_OUT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = c_q;
                if (bus.out_ready) begin
                    state_d = last_blk ? S_IDLE : S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The tweak register holds the raw sector tweak until the key2 op returns T0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key1_q <= '0;
            key2_q <= '0;
            t_q    <= '0;
            x_q    <= '0;
            c_q    <= '0;
            nblk_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        key1_q <= bus.key1;
                        key2_q <= bus.key2;
                        t_q    <= bus.tweak;
                        nblk_q <= bus.nblk;
                        cnt_q  <= '0;
                        done_q <= (bus.nblk == '0);
                    end
                end
                S_TWK_RUN: begin
                    if (bus.core_valid) begin
                        t_q <= bus.core_rdata;
                    end
                end
                S_BLK_IN: begin
                    if (bus.in_valid) begin
                        x_q <= bus.in_data ^ t_q;
                    end
                end
                S_BLK_RUN: begin
                    if (bus.core_valid) begin
                        c_q <= bus.core_rdata ^ t_q;
                    end
                end
                S_BLK_OUT: begin
                    if (bus.out_ready) begin
                        t_q    <= t_alpha;
                        cnt_q  <= cnt_q + NBLK_W'(1);
                        done_q <= last_blk;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;

endmodule

`default_nettype wire
